ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 16: number of configuration flip-flops in the downstream chain; legal range 1..65535.
REQ-002 Parameter WORD_W, default 8: width of each bitstream word; legal range 1..32.
REQ-003 prog_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 prog_resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a chain load; honoured only in IDLE or DONE.
REQ-006 abort  input  1  terminates a load in progress.
REQ-007 cfg_data  input  WORD_W  bitstream word, transmitted MSB first.
REQ-008 cfg_valid  input  1  cfg_data is valid.
REQ-009 cfg_ready  output  1  loader accepts cfg_data on this edge when cfg_valid is also high.
REQ-010 ccff_head  output  1  serial data to the chain's ccff_head.
REQ-011 ccff_clk_en  output  1  enable for the chain's prog_clk gate; the chain shifts one bit on every prog_clk edge where this is high.
REQ-012 busy  output  1  high in LOAD and SHIFT.
REQ-013 done  output  1  high in DONE.
REQ-014 bit_count  output  clog2(CHAIN_LEN+1)  number of bits shifted into the chain since the last start.

Function
REQ-015 The loader SHALL implement the states IDLE, LOAD, SHIFT and DONE, with IDLE as the reset state.
REQ-016 IDLE/DONE + start=1 SHALL go to LOAD, clear bit_count to 0 and clear done.
REQ-017 LOAD SHALL drive cfg_ready=1 and ccff_clk_en=0; cfg_valid&cfg_ready SHALL capture cfg_data into a WORD_W shift register, set the word-bit counter to WORD_W and go to SHIFT.
REQ-018 SHIFT SHALL drive ccff_head = shift register MSB and ccff_clk_en=1 every cycle, and SHALL on each edge shift the register left, increment bit_count and decrement the word-bit counter.
REQ-019 ccff_head and ccff_clk_en SHALL be driven directly from registers (glitch-free) and SHALL be stable for the whole cycle.
REQ-020 On the last bit of a word (word-bit counter = 1, bit_count+1 < CHAIN_LEN), SHIFT SHALL assert cfg_ready. If a word is accepted, the next word SHALL load with no bubble (1 bit/cycle sustained); otherwise the state SHALL go to LOAD.
REQ-021 In LOAD with cfg_valid=0 (stall), ccff_clk_en SHALL stay 0 and the chain SHALL not shift.
REQ-022 When bit_count reaches CHAIN_LEN, the state SHALL go to DONE in the same edge, ccff_clk_en SHALL be 0 from the next cycle, and the remaining bits of the current word SHALL be discarded.
REQ-023 cfg_ready SHALL be 0 once the final bit has been shifted.
REQ-024 The first bit shifted SHALL end in the chain's last flop (mem_out[CHAIN_LEN-1]).
REQ-025 DONE SHALL hold done=1 and bit_count=CHAIN_LEN until start or abort.
REQ-026 start in LOAD or SHIFT SHALL be ignored.
REQ-027 abort=1 in any state SHALL go to IDLE on the next edge and force ccff_clk_en=0 and cfg_ready=0 from that edge; bit_count SHALL hold its value.
REQ-028 abort SHALL take priority over start and over a handshake on the same edge; no word is accepted on that edge.
REQ-029 ccff_head SHALL be 0 whenever ccff_clk_en=0.

Reset
REQ-030 prog_resetn=0 SHALL immediately force IDLE, cfg_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0 and bit_count=0, clear the shift register and word-bit counter, and hold these values while asserted.
REQ-031 Reset asserted mid-SHIFT SHALL drop ccff_clk_en asynchronously so that no further chain shift occurs.
REQ-032 After release, the loader SHALL stay in IDLE until start.

Verification
REQ-033 CHAIN_LEN=16, WORD_W=8, start, then words 0xA5 and 0x3C presented back-to-back -> ccff_head sequence 1010_0101_0011_1100 on 16 consecutive ccff_clk_en cycles with no gap, done=1, bit_count=16, chain mem_out[15..0]=A53C read MSB→mem_out[15].
REQ-034 CHAIN_LEN=3, word 0xE0 -> exactly 3 enabled cycles with head=1,1,1, done asserted, cfg_ready never reasserted, remaining 5 bits discarded.
REQ-035 CHAIN_LEN=16, cfg_valid held low for 5 cycles between words -> ccff_clk_en low for exactly those 5 cycles, then 8 enabled cycles, final bit_count=16.
REQ-036 abort after 4 shifted bits -> IDLE next edge, ccff_clk_en=0, bit_count=4, done=0; a subsequent start reloads from bit_count=0.
REQ-037 prog_resetn low during SHIFT at bit 6 -> all outputs zero immediately; no chain shift on the following edges; start after release loads normally.
REQ-038 start pulsed in SHIFT, and abort together with cfg_valid in LOAD -> start ignored; abort wins and no word is consumed.

Source files
------------

// File: rtl/ccff_loader_if.sv
// Word stream from the bitstream source into the configuration-chain loader.
interface ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_loader.sv
// Serialises bitstream words MSB first into a configuration flip-flop chain,
// gating the chain clock so exactly CHAIN_LEN bits are shifted per load.
//
// state | meaning
// IDLE  | waiting for start (reset state)
// LOAD  | cfg_ready high, waiting for a word; chain clock gated off
// SHIFT | one bit per cycle into the chain
// DONE  | CHAIN_LEN bits shifted, done held until start or abort
module ccff_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic                           prog_clk,
  input  logic                           prog_resetn,
  input  logic                           start,
  input  logic                           abort,
  ccff_loader_if.slave                   cfg,
  output logic                           ccff_head,
  output logic                           ccff_clk_en,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

  localparam int CW  = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [WCW-1:0]    wcnt;
  logic              ready_q;

  logic [CW-1:0]     bc_nxt;
  logic [WORD_W-1:0] sh;
  logic              chain_full;
  logic              more_next;
  logic              word_last;
  logic              accept;

  always_comb begin
    bc_nxt     = bit_count + CW'(1);
    sh         = sreg << 1;
    chain_full = (bc_nxt == CW'(CHAIN_LEN));
    // another bit will still be needed after the one shifted on the next edge
    more_next  = (int'(bc_nxt) + 1) < CHAIN_LEN;
    word_last  = (wcnt == WCW'(1));
    accept     = cfg.cfg_valid && ready_q;
  end

  always_ff @(posedge prog_clk or negedge prog_resetn) begin
    if (!prog_resetn) begin
      state       <= IDLE;
      sreg        <= '0;
      wcnt        <= '0;
      bit_count   <= '0;
      ready_q     <= 1'b0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            bit_count <= '0;
            ready_q   <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg.cfg_valid) begin
            state       <= SHIFT;
            sreg        <= cfg.cfg_data;
            wcnt        <= WCW'(WORD_W);
            ccff_head   <= cfg.cfg_data[WORD_W-1];
            ccff_clk_en <= 1'b1;
            ready_q     <= (WORD_W == 1) && ((int'(bit_count) + 1) < CHAIN_LEN);
          end
        end
        SHIFT: begin
          bit_count <= bc_nxt;
          sreg      <= sh;
          wcnt      <= wcnt - WCW'(1);
          if (chain_full) begin
            // leftover bits of the current word are dropped here
            state       <= DONE;
            ready_q     <= 1'b0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
          end else if (word_last) begin
            if (accept) begin
              sreg      <= cfg.cfg_data;
              wcnt      <= WCW'(WORD_W);
              ccff_head <= cfg.cfg_data[WORD_W-1];
              ready_q   <= (WORD_W == 1) && more_next;
            end else begin
              state       <= LOAD;
              ready_q     <= 1'b1;
              ccff_head   <= 1'b0;
              ccff_clk_en <= 1'b0;
            end
          end else begin
            ccff_head <= sh[WORD_W-1];
            ready_q   <= (int'(wcnt) == 2) && more_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign busy          = (state == LOAD) || (state == SHIFT);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench: expected chain bits are queued per accepted word and
// popped by a monitor on every enabled chain cycle; chains are modelled too.
module tb_ccff_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic       head_a, en_a, busy_a, done_a;
  logic       head_b, en_b, busy_b, done_b;
  logic [4:0] bc_a;
  logic [1:0] bc_b;

  ccff_loader_if #(.WORD_W(8)) ifa ();
  ccff_loader_if #(.WORD_W(8)) ifb ();

  ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .prog_clk(clk), .prog_resetn(rst_n), .start(start_a), .abort(abort_a),
    .cfg(ifa.slave), .ccff_head(head_a), .ccff_clk_en(en_a),
    .busy(busy_a), .done(done_a), .bit_count(bc_a));

  ccff_loader #(.CHAIN_LEN(3), .WORD_W(8)) dut_b (
    .prog_clk(clk), .prog_resetn(rst_n), .start(start_b), .abort(abort_b),
    .cfg(ifb.slave), .ccff_head(head_b), .ccff_clk_en(en_b),
    .busy(busy_b), .done(done_b), .bit_count(bc_b));

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  bit qa[$];
  bit qb[$];
  int rem_a = 0;
  int rem_b = 0;
  int en_tot_a = 0, low_tot_a = 0, en_tot_b = 0, rdy_en_b = 0;
  logic [15:0] mem_a = '0;
  logic [2:0]  mem_b = '0;

  // chain models: first bit shifted ends in the last flop
  always @(posedge clk) begin
    if (en_a) mem_a <= {mem_a[14:0], head_a};
    if (en_b) mem_b <= {mem_b[1:0], head_b};
  end

  always @(negedge clk) begin
    if (en_a) begin
      en_tot_a++;
      if (qa.size() == 0) chk("head_a_unexpected", 32'(en_a), 0);
      else chk("head_a", 32'(head_a), 32'(qa.pop_front()));
    end else begin
      chk("head_a_gated", 32'(head_a), 0);
      if (busy_a && bc_a != 0) low_tot_a++;
    end
    if (en_b) begin
      en_tot_b++;
      if (ifb.cfg_ready) rdy_en_b++;
      if (qb.size() == 0) chk("head_b_unexpected", 32'(en_b), 0);
      else chk("head_b", 32'(head_b), 32'(qb.pop_front()));
    end else begin
      chk("head_b_gated", 32'(head_b), 0);
    end
  end

  task automatic start_pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    rem_a = 16;
  endtask

  task automatic send_a(input logic [7:0] d);
    int n = 0;
    ifa.cfg_data  = d;
    ifa.cfg_valid = 1'b1;
    while (!ifa.cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_a_timeout", 32'(ifa.cfg_ready), 1);
    @(posedge clk);
    for (int i = 7; i >= 0 && rem_a > 0; i--) begin
      qa.push_back(d[i]);
      rem_a--;
    end
    @(negedge clk);
    ifa.cfg_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_a", 32'(done_a), 1);
  endtask

  task automatic full_load_a();
    start_pulse_a();
    send_a(8'hA5);
    send_a(8'h3C);
    wait_done_a();
    chk("full_bc_a", 32'(bc_a), 16);
    chk("full_mem_a", 32'(mem_a), 32'h0000_A53C);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, l0, n;
    logic [15:0] snap;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    ifa.cfg_valid = 1'b0; ifa.cfg_data = '0;
    ifb.cfg_valid = 1'b0; ifb.cfg_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ifa.cfg_ready), 0);
    chk("rst_head", 32'(head_a), 0);
    chk("rst_en", 32'(en_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_bc", 32'(bc_a), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(busy_a), 0);

    // back-to-back words A5, 3C
    e0 = en_tot_a; l0 = low_tot_a;
    full_load_a();
    chk("t1_done", 32'(done_a), 1);
    chk("t1_en_cycles", 32'(en_tot_a - e0), 16);
    chk("t1_no_gap", 32'(low_tot_a - l0), 0);
    chk("t1_ready_low", 32'(ifa.cfg_ready), 0);
    chk("t1_en_low", 32'(en_a), 0);
    chk("t1_queue_empty", 32'(qa.size()), 0);
    repeat (3) @(negedge clk);
    chk("t1_done_hold", 32'(done_a), 1);
    chk("t1_bc_hold", 32'(bc_a), 16);

    // five-cycle stall between words
    e0 = en_tot_a; l0 = low_tot_a;
    start_pulse_a();
    send_a(8'hA5);
    n = 0;
    while (en_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    send_a(8'h3C);
    wait_done_a();
    chk("t3_stall_cycles", 32'(low_tot_a - l0), 5);
    chk("t3_en_cycles", 32'(en_tot_a - e0), 16);
    chk("t3_bc", 32'(bc_a), 16);
    chk("t3_mem", 32'(mem_a), 32'h0000_A53C);

    // abort after 4 shifted bits
    start_pulse_a();
    send_a(8'hA5);
    repeat (4) @(negedge clk);
    chk("t4_bc_before", 32'(bc_a), 4);
    abort_a = 1'b1;
    @(negedge clk) abort_a = 1'b0;
    chk("t4_busy", 32'(busy_a), 0);
    chk("t4_done", 32'(done_a), 0);
    chk("t4_en", 32'(en_a), 0);
    chk("t4_ready", 32'(ifa.cfg_ready), 0);
    chk("t4_bc", 32'(bc_a), 4);
    chk("t4_unshifted", 32'(qa.size()), 3);
    qa.delete();
    start_pulse_a();
    chk("t4_restart_bc", 32'(bc_a), 0);
    send_a(8'hA5);
    send_a(8'h3C);
    wait_done_a();
    chk("t4_reload_mem", 32'(mem_a), 32'h0000_A53C);
    chk("t4_reload_bc", 32'(bc_a), 16);

    // start during SHIFT is ignored
    start_pulse_a();
    send_a(8'hA5);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    send_a(8'h3C);
    wait_done_a();
    chk("t6_bc", 32'(bc_a), 16);
    chk("t6_mem", 32'(mem_a), 32'h0000_A53C);

    // abort together with a valid word in LOAD
    start_pulse_a();
    e0 = en_tot_a;
    ifa.cfg_data = 8'hFF; ifa.cfg_valid = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0; ifa.cfg_valid = 1'b0;
    chk("t6_abort_busy", 32'(busy_a), 0);
    chk("t6_abort_ready", 32'(ifa.cfg_ready), 0);
    chk("t6_abort_bc", 32'(bc_a), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_word", 32'(en_tot_a - e0), 0);

    // reset during SHIFT at bit 6
    start_pulse_a();
    send_a(8'hA5);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_en", 32'(en_a), 0);
    chk("t5_head", 32'(head_a), 0);
    chk("t5_ready", 32'(ifa.cfg_ready), 0);
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_bc", 32'(bc_a), 0);
    snap = mem_a;
    repeat (3) @(negedge clk);
    chk("t5_no_shift", 32'(mem_a), 32'(snap));
    chk("t5_unshifted", 32'(qa.size()), 1);
    qa.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle", 32'(busy_a), 0);
    full_load_a();

    // short chain: only 3 bits of E0 used
    e0 = en_tot_b; l0 = rdy_en_b;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    rem_b = 3;
    ifb.cfg_data = 8'hE0; ifb.cfg_valid = 1'b1;
    n = 0;
    while (!ifb.cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    for (int i = 7; i >= 0 && rem_b > 0; i--) begin
      qb.push_back(ifb.cfg_data[i]);
      rem_b--;
    end
    @(negedge clk) ifb.cfg_valid = 1'b0;
    n = 0;
    while (!done_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t2_done", 32'(done_b), 1);
    chk("t2_bc", 32'(bc_b), 3);
    chk("t2_en_cycles", 32'(en_tot_b - e0), 3);
    chk("t2_mem", 32'(mem_b), 7);
    chk("t2_ready_in_shift", 32'(rdy_en_b - l0), 0);
    chk("t2_ready_after", 32'(ifb.cfg_ready), 0);
    chk("t2_queue_empty", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
